// File: rtl/spi_sram_ctrl_if.sv
// CPU-side memory bus between the NEANDER-X control unit and the SPI SRAM controller.
// The CPU is the master; the controller is the slave.
interface spi_sram_ctrl_if;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic        mem_read;
    logic        mem_write;
    logic        mem_req;
    logic        mem_ready;
    logic [7:0]  mem_data_in;
    logic        busy;

    modport master (
        output mem_addr, mem_data_out, mem_read, mem_write, mem_req,
        input  mem_ready, mem_data_in, busy
    );

    modport slave (
        input  mem_addr, mem_data_out, mem_read, mem_write, mem_req,
        output mem_ready, mem_data_in, busy
    );
endinterface

// File: rtl/spi_sram_ctrl.sv
// Byte-wide CPU memory access performed as one 32-bit SPI transaction on a 23LC512-class SRAM.
// Define RD_CACHE_EN to add a one-entry write-through read cache.
module spi_sram_ctrl #(
    parameter int         CLK_DIV   = 1,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic            clk,
    input  logic            reset,
    spi_sram_ctrl_if.slave  bus,
    output logic            spi_cs_n,
    output logic            spi_sclk,
    output logic            spi_mosi,
    input  logic            spi_miso
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    state_t           state_q, state_d;
    logic [31:0]      tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             phase_q, phase_d;
    logic             is_write_q, is_write_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             start;
    logic             ready;
    logic             busy;
`ifdef RD_CACHE_EN
    logic             cache_valid_q, cache_valid_d;
    logic [15:0]      cache_tag_q, cache_tag_d;
    logic [7:0]       cache_data_q, cache_data_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             hit;

    assign hit = cache_valid_q && bus.mem_read && !bus.mem_write && (cache_tag_q == bus.mem_addr);
`endif

    assign start           = bus.mem_req && (bus.mem_read || bus.mem_write);
    assign bus.mem_ready   = ready;
    assign bus.busy        = busy;
    assign bus.mem_data_in = rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            tx_q          <= '0;
            rx_q          <= '0;
            bit_cnt_q     <= '0;
            div_cnt_q     <= '0;
            phase_q       <= 1'b0;
            is_write_q    <= 1'b0;
            rdata_q       <= '0;
`ifdef RD_CACHE_EN
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            bit_cnt_q     <= bit_cnt_d;
            div_cnt_q     <= div_cnt_d;
            phase_q       <= phase_d;
            is_write_q    <= is_write_d;
            rdata_q       <= rdata_d;
`ifdef RD_CACHE_EN
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        phase_d    = phase_q;
        is_write_d = is_write_q;
        rdata_d    = rdata_q;
`ifdef RD_CACHE_EN
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    is_write_d = bus.mem_write;
                    tx_d       = {bus.mem_write ? CMD_WRITE : CMD_READ, bus.mem_addr,
                                  bus.mem_write ? bus.mem_data_out : 8'h00};
                    state_d    = SETUP;
`ifdef RD_CACHE_EN
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_data_out;
                    if (hit) begin
                        state_d = DONE;
                        rdata_d = cache_data_q;
                    end
`endif
                end
            end
            SETUP: begin
                div_cnt_d = '0;
                phase_d   = 1'b0;
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                // MISO is captured as SCLK rises; MOSI advances only as SCLK falls.
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        rx_d    = {rx_q[6:0], spi_miso};
                    end else begin
                        phase_d = 1'b0;
                        if (bit_cnt_q == 5'd31) begin
                            state_d = HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            tx_d      = {tx_q[30:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            HOLD: begin
                if (!is_write_q) begin
                    rdata_d = rx_q;
                end
`ifdef RD_CACHE_EN
                if (!is_write_q) begin
                    cache_valid_d = 1'b1;
                    cache_tag_d   = addr_q;
                    cache_data_d  = rx_q;
                end else if (cache_valid_q && (cache_tag_q == addr_q)) begin
                    cache_data_d = wdata_q;
                end
`endif
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        ready    = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            SETUP: begin
                spi_cs_n = 1'b0;
                spi_mosi = tx_q[31];
            end
            SHIFT: begin
                spi_cs_n = 1'b0;
                spi_sclk = phase_q;
                spi_mosi = tx_q[31];
            end
            DONE:    ready = 1'b1;
            default: ;
        endcase
    end
endmodule
